// File: rtl/z_cla_pipe.sv
// ---------------------------------------------------------------------------
// z_cla_pipe -- three-stage pipelined carry-lookahead adder/subtractor
//
// Computes a+b+cin (sub=0) or a-b (sub=1) with a two-level lookahead carry
// network split over three register stages:
//   S1: per-bit propagate/generate and effective carry-in
//   S2: group propagate/generate and the carry into every group
//   S3: in-group carries, sum, cout, ovf and zero, registered as outputs
// A single global stall holds every stage while a result is presented but
// not taken, so the pipeline behaves like one valid/ready stage of depth 3.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears all valid bits/outputs
//   in_valid   operand beat offered
//   in_ready   block accepts the beat this cycle (combinational)
//   a, b       operands, WIDTH bits
//   cin        carry-in, ignored when sub=1
//   sub        0: a+b+cin   1: a-b (a + ~b + 1)
//   out_valid  result beat present
//   out_ready  consumer accepts the result beat
//   sum        result, modulo 2^WIDTH
//   cout       carry out of the MSB (for sub, 1 = no borrow)
//   ovf        signed overflow
//   zero       sum == 0
// ---------------------------------------------------------------------------
module z_cla_pipe #(
    parameter int WIDTH = 16,
    parameter int GRP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GRP;

    // Every stage advances together; a result waiting on the consumer
    // freezes the whole pipe.
    logic adv;
    assign in_ready = !(out_valid && !out_ready);
    assign adv      = in_ready;

    // ---------------- S1: bit propagate / generate ----------------
    logic [WIDTH-1:0] b_eff;
    assign b_eff = sub ? ~b : b;

    logic             v1;
    logic [WIDTH-1:0] p1, g1;
    logic             c0_1;

    // NOTE: state registers use non-blocking assignments so every stage
    // samples the previous stage's value from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            // NOTE: datapath registers are reset too; it is cheap here and
            // keeps the outputs at a defined 0 during and after reset.
            p1   <= '0;
            g1   <= '0;
            c0_1 <= 1'b0;
        end else if (adv) begin
            v1   <= in_valid;
            p1   <= a ^ b_eff;
            g1   <= a & b_eff;
            c0_1 <= sub | cin;
        end
    end

    // ---------------- S2: group lookahead ----------------
    logic [NG:0] gcarry;
    logic        grp_p, grp_g;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        gcarry    = '0;
        grp_p     = 1'b0;
        grp_g     = 1'b0;
        gcarry[0] = c0_1;
        for (int k = 0; k < NG; k++) begin
            grp_p = 1'b1;
            grp_g = 1'b0;
            for (int j = 0; j < GRP; j++) begin
                grp_g = g1[k*GRP+j] | (p1[k*GRP+j] & grp_g);
                grp_p = grp_p & p1[k*GRP+j];
            end
            gcarry[k+1] = grp_g | (grp_p & gcarry[k]);
        end
    end

    logic             v2;
    logic [WIDTH-1:0] p2, g2;
    logic [NG-1:0]    gc2;   // carry into each group

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2  <= 1'b0;
            p2  <= '0;
            g2  <= '0;
            gc2 <= '0;
        end else if (adv) begin
            v2  <= v1;
            p2  <= p1;
            g2  <= g1;
            gc2 <= gcarry[NG-1:0];
        end
    end

    // ---------------- S3: in-group carries and flags ----------------
    logic [WIDTH-1:0] sum_n;
    logic             c_run, c_msb, cout_n;

    // Each group restarts from its lookahead carry, so the in-group ripple
    // is only GRP bits deep.
    always_comb begin
        sum_n  = '0;
        c_run  = 1'b0;
        c_msb  = 1'b0;
        cout_n = 1'b0;
        for (int k = 0; k < NG; k++) begin
            c_run = gc2[k];
            for (int j = 0; j < GRP; j++) begin
                sum_n[k*GRP+j] = p2[k*GRP+j] ^ c_run;
                if (k*GRP+j == WIDTH-1) c_msb = c_run;
                c_run = g2[k*GRP+j] | (p2[k*GRP+j] & c_run);
            end
        end
        cout_n = c_run;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            out_valid <= v2;
            sum       <= sum_n;
            cout      <= cout_n;
            ovf       <= cout_n ^ c_msb;
            zero      <= (sum_n == '0);
        end
    end

endmodule

// File: tb/tb_z_cla_pipe.sv
// ---------------------------------------------------------------------------
// tb_z_cla_pipe -- self-checking bench for z_cla_pipe (WIDTH=16, GRP=4)
//
// Accepted beats push an arithmetic-model result into a queue; a negedge
// monitor pops and compares on every output handshake and checks that a
// stalled result holds. Directed cases, a stall scenario, an asynchronous
// mid-flight reset and a long random run are layered on top.
// ---------------------------------------------------------------------------
module tb_z_cla_pipe;

    typedef struct packed {
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [15:0] sum;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout, ovf, zero;

    int   n_checks = 0;
    int   n_err    = 0;
    int   n_acc    = 0;
    res_t sb_q[$];
    bit   held_prev = 1'b0;
    res_t held_val;

    z_cla_pipe #(.WIDTH(16), .GRP(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, signed range for overflow,
    // unsigned compare for borrow.
    function automatic res_t model(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin, input logic tsub);
        res_t r;
        int   ua, ub, u, sa, sbv, s;
        ua  = int'(ta);
        ub  = int'(tb_);
        sa  = int'($signed(ta));
        sbv = int'($signed(tb_));
        if (tsub) begin
            u      = ua - ub;
            s      = sa - sbv;
            r.cout = (ua >= ub);
        end else begin
            u      = ua + ub + int'(tcin);
            s      = sa + sbv + int'(tcin);
            r.cout = (u > 65535);
        end
        r.sum  = u[15:0];
        r.ovf  = (s > 32767) || (s < -32768);
        r.zero = (r.sum == 16'h0000);
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.cout = cout;
        r.ovf  = ovf;
        r.zero = zero;
        r.sum  = sum;
        return r;
    endfunction

    // Monitor: values are stable at the falling edge; a handshake seen here
    // completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (held_prev)
                check(out_valid && (dut_res() == held_val), "hold_while_stalled",
                      {12'h0, out_valid, dut_res()}, {12'h0, 1'b1, held_val});
            held_prev = out_valid && !out_ready;
            held_val  = dut_res();
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check(1'b0, "unexpected_output", {13'h0, dut_res()}, 32'h0);
                end else begin
                    res_t e;
                    e = sb_q.pop_front();
                    check(dut_res() == e, "scoreboard", {13'h0, dut_res()}, {13'h0, e});
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(a, b, cin, sub));
                n_acc++;
            end
        end
    end

    // Offer one beat starting at posedge+1 and hold it until taken.
    task automatic send_beat(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin, input logic tsub);
        int n;
        in_valid = 1'b1; a = ta; b = tb_; cin = tcin; sub = tsub;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                check(1'b0, "send_timeout", 32'(n), 32'd50);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin, input logic tsub,
                            input logic [15:0] esum, input logic ecout, input logic eovf, input logic ezero,
                            input string nm);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; a = ta; b = tb_; cin = tcin; sub = tsub;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check(lat == 3, {nm, "_latency"}, 32'(lat), 32'd3);
        check({sum, cout, ovf, zero} == {esum, ecout, eovf, ezero}, nm,
              {13'h0, sum, cout, ovf, zero}, {13'h0, esum, ecout, eovf, ezero});
    endtask

    initial begin
        int cyc, seen, target;

        // ---- reset state ----
        #12;
        check(!out_valid && sum == 0 && !cout && !ovf && !zero, "reset_outputs",
              {12'h0, out_valid, sum, cout, ovf, zero}, 32'h0);
        check(in_ready == 1'b1, "reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        check(in_ready == 1'b1, "post_reset_in_ready", 32'(in_ready), 32'd1);

        // ---- directed arithmetic ----
        directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "add_wrap");
        directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "add_ovf");
        directed(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub_borrow");
        directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
        directed(16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0, 1'b0, "add_cin");
        repeat (3) @(posedge clk);

        // ---- stall: stream 5 beats, block the first result ----
        #1;
        fork
            begin
                for (int i = 1; i <= 5; i++)
                    send_beat(16'(i), 16'(i * 256), 1'b0, 1'b0);
            end
            begin
                cyc = 0;
                do begin
                    @(posedge clk); #1;
                    cyc++;
                end while (!out_valid && cyc < 20);
                out_ready = 1'b0;
                #1;
                check(in_ready == 1'b0, "stall_in_ready", 32'(in_ready), 32'd0);
                for (int k = 0; k < 4; k++) begin
                    check(out_valid && sum == 16'h0101, "stall_frozen", {15'h0, out_valid, sum}, 32'h10101);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
                check(out_valid && sum == 16'h0101, "release_beat1", {15'h0, out_valid, sum}, 32'h10101);
                for (int k = 2; k <= 5; k++) begin
                    @(posedge clk); #1;
                    check(out_valid && sum == 16'(k * 16'h0101), "release_order",
                          {15'h0, out_valid, sum}, {15'h0, 1'b1, 16'(k * 16'h0101)});
                end
            end
        join
        repeat (4) @(posedge clk);
        check(sb_q.size() == 0, "stall_drained", 32'(sb_q.size()), 32'd0);

        // ---- asynchronous reset with 3 beats in flight ----
        #1;
        out_ready = 1'b1;
        send_beat(16'h1111, 16'h2222, 1'b0, 1'b0);
        send_beat(16'h3333, 16'h4444, 1'b1, 1'b0);
        send_beat(16'h5555, 16'h0001, 1'b0, 1'b1);
        #2;                    // between edges
        rst = 1'b1;
        #1;
        check(!out_valid && sum == 0 && !cout && !ovf && !zero, "async_reset_outputs",
              {12'h0, out_valid, sum, cout, ovf, zero}, 32'h0);
        check(in_ready == 1'b1, "async_reset_in_ready", 32'(in_ready), 32'd1);
        sb_q.delete();
        held_prev = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check(seen == 0, "no_discarded_beats", 32'(seen), 32'd0);
        directed(16'h00FF, 16'hFF01, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "first_after_reset");

        // ---- random traffic ----
        target = n_acc + 10000;
        cyc = 0;
        while (n_acc < target && cyc < 60000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            case ($urandom_range(7))
                0: a = 16'hFFFF;
                1: begin a = 16'h8000; b = 16'h7FFF; end
                default: ;
            endcase
            cyc++;
        end
        check(n_acc >= target, "random_progress", 32'(n_acc), 32'(target));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        check(sb_q.size() == 0, "final_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/z_cla_pipe.md
Z_CLA_PIPE -- requirements
Module: z_cla_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width; SHALL be a multiple of GRP, minimum 4.
REQ-002 Parameter GRP, default 4, lookahead group size in bits.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  input  1  operand beat offered.
REQ-006 Port in_ready  output  1  block accepts the beat this cycle.
REQ-007 Port a, b  input  WIDTH  operands.
REQ-008 Port cin  input  1  carry-in; ignored when sub=1.
REQ-009 Port sub  input  1  0 = a+b+cin; 1 = a-b (a + ~b + 1).
REQ-010 Port out_valid  output  1  result beat present.
REQ-011 Port out_ready  input  1  consumer accepts the result beat.
REQ-012 Port sum  output  WIDTH  result.
REQ-013 Port cout  output  1  carry out of the MSB; for sub, 1 = no borrow.
REQ-014 Port ovf  output  1  signed overflow.
REQ-015 Port zero  output  1  sum == 0.

Function
REQ-016 SHALL be a 3-stage pipeline; each stage holds a valid bit.
  S1: register per-bit prop = a^b' and gen = a&b', with b' = sub ? ~b : b, and effective carry-in c0 = sub ? 1 : cin.
  S2: group P/G per GRP-bit group; lookahead carries into every group; register them.
  S3: sum bits, cout, ovf and zero, registered to the outputs.
REQ-017 Latency SHALL be exactly 3 clk cycles from an accepted beat to out_valid, absent stall.
REQ-018 A beat SHALL be accepted on a rising edge only when in_valid=1 and in_ready=1.
REQ-019 in_ready SHALL equal !(out_valid && !out_ready): global stall, fully combinational.
REQ-020 While stalled, all stage registers and outputs SHALL hold; no beat is lost or duplicated.
REQ-021 A bubble (in_valid=0 when in_ready=1) SHALL propagate as valid=0; out_valid may then drop.
REQ-022 Throughput SHALL be one beat per cycle when out_ready is held 1.
REQ-023 Carry arithmetic:
  c[i+1] = g[i] | (p[i] & c[i]), realised as two-level lookahead (bit-in-group, group-in-word).
  sum[i] = p[i] ^ c[i].
  cout = c[WIDTH].
REQ-024 ovf SHALL equal c[WIDTH] ^ c[WIDTH-1].
REQ-025 sum SHALL wrap modulo 2^WIDTH.
REQ-026 sum, cout, ovf and zero SHALL be valid only while out_valid=1; they SHALL hold stable until the handshake completes.
REQ-027 sub and cin SHALL be sampled with a and b in the same accepted beat; a per-beat mode change SHALL not affect beats in flight.

Reset
REQ-028 rst=1 SHALL immediately clear all stage valid bits, out_valid, sum, cout, ovf and zero to 0.
REQ-029 zero SHALL read 0 during reset, not 1.
REQ-030 in_ready SHALL be 1 during and after reset.
REQ-031 Reset mid-operation SHALL discard all in-flight beats.
REQ-032 After rst deasserts, the first accepted beat SHALL appear after 3 cycles.

Verification (WIDTH=16, GRP=4)
REQ-033 Add with wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 3 cycles later sum=0x0000, cout=1, zero=1, ovf=0.
REQ-034 Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1, zero=0.
REQ-035 Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0; then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1, cout=1.
REQ-036 Stall: stream 5 beats; out_ready=0 when the first result is presented.
  -> in_ready=0 in that same cycle.
  -> outputs frozen on beat 1.
  -> on release, beats 1..5 emerge in order, one per cycle, no loss or duplication.
REQ-037 Random carry chains: 10k random a, b, cin and sub, with random in_valid/out_ready -> every result matches a reference model; ovf and cout match the bit-level definitions.
REQ-038 Reset mid-flight: assert rst asynchronously between edges with 3 beats in flight.
  -> out_valid=0 and outputs=0 at once, with no clock edge needed.
  -> after release, none of the discarded beats appear.
